// File: rtl/drum_mul_share_arbiter.sv
// Round-robin arbiter sharing one signed DRUM approximate multiplier among N_REQ requesters,
// with a two-stage registered pipeline and a backpressured, ID-tagged response channel.

module DRUMk_M_N_s #(
  parameter int K = 6,
  parameter int M = 16,
  parameter int N = 16
) (
  input  logic [N-1:0]   a,
  input  logic [M-1:0]   b,
  output logic [N+M-1:0] r
);
  logic [N-1:0]   w_a_mag;
  logic [M-1:0]   w_b_mag;
  logic [K-1:0]   w_a_k;
  logic [K-1:0]   w_b_k;
  int             w_a_sh;
  int             w_b_sh;
  logic [N+M-1:0] w_mag_prod;
  logic           w_sign;

  // Keep K bits below the leading one; forcing the kept LSB to 1 unbiases the truncation.
  function automatic logic [K-1:0] drum_trunc(input logic [N+M-1:0] mag, output int sh);
    int lead;
    lead = 0;
    for (int i = 0; i < N + M; i++)
      if (mag[i]) lead = i;
    if (lead >= K) begin
      sh         = lead - K + 1;
      drum_trunc = K'(mag >> sh) | K'(1);
    end else begin
      sh         = 0;
      drum_trunc = mag[K-1:0];
    end
  endfunction

  // Magnitudes are one's complement, so negative results come out as ~|p| rather than -|p|.
  assign w_a_mag = a[N-1] ? ~a : a;
  assign w_b_mag = b[M-1] ? ~b : b;
  assign w_sign  = a[N-1] ^ b[M-1];

  always_comb begin
    w_a_sh     = 0;
    w_b_sh     = 0;
    w_a_k      = drum_trunc((N+M)'(w_a_mag), w_a_sh);
    w_b_k      = drum_trunc((N+M)'(w_b_mag), w_b_sh);
    w_mag_prod = ((N+M)'(w_a_k) * (N+M)'(w_b_k)) << (w_a_sh + w_b_sh);
  end

  assign r = w_sign ? ~w_mag_prod : w_mag_prod;
endmodule

module drum_mul_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int K     = 6,
  parameter int N     = 16,
  parameter int M     = 16,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*N-1:0] req_a,
  input  logic [N_REQ*M-1:0] req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [ID_W-1:0]    rsp_id,
  output logic [N+M-1:0]     rsp_data,
  output logic [31:0]        op_count
);
  logic            r_v1;
  logic            r_v2;
  logic [N-1:0]    r_a1;
  logic [M-1:0]    r_b1;
  logic [ID_W-1:0] r_id1;
  logic [ID_W-1:0] r_id2;
  logic [N+M-1:0]  r_prod2;
  logic [ID_W-1:0] r_ptr;
  logic [31:0]     r_op_count;

  logic            w_adv1;
  logic            w_adv2;
  logic            w_grant_vld;
  logic            w_hs;
  logic [ID_W-1:0] w_grant_id;
  logic [ID_W-1:0] w_ptr_next;
  logic [N-1:0]    w_sel_a;
  logic [M-1:0]    w_sel_b;
  logic [N+M-1:0]  w_prod;

  assign w_adv2 = !r_v2 || rsp_ready;
  assign w_adv1 = !r_v1 || w_adv2;

  // Rotating priority search starting at the pointer.
  always_comb begin
    int idx;
    idx         = 0;
    w_grant_vld = 1'b0;
    w_grant_id  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(r_ptr) + i) % N_REQ;
      if (!w_grant_vld && req_valid[idx]) begin
        w_grant_vld = 1'b1;
        w_grant_id  = ID_W'(idx);
      end
    end
  end

  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant_id == ID_W'(i)) begin
        w_sel_a = req_a[i*N +: N];
        w_sel_b = req_b[i*M +: M];
      end
    end
  end

  assign w_hs       = w_adv1 && w_grant_vld && !rst;
  assign req_ready  = w_hs ? (N_REQ'(1) << w_grant_id) : '0;
  assign w_ptr_next = (w_grant_id == ID_W'(N_REQ - 1)) ? '0 : w_grant_id + 1'b1;

  DRUMk_M_N_s #(.K(K), .M(M), .N(N)) u_drum (
    .a (r_a1),
    .b (r_b1),
    .r (w_prod)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1       <= 1'b0;
      r_v2       <= 1'b0;
      r_a1       <= '0;
      r_b1       <= '0;
      r_id1      <= '0;
      r_id2      <= '0;
      r_prod2    <= '0;
      r_ptr      <= '0;
      r_op_count <= '0;
    end else begin
      if (w_hs) begin
        r_ptr      <= w_ptr_next;
        r_op_count <= r_op_count + 32'd1;
      end
      if (w_adv2) begin
        r_v2 <= r_v1;
        if (r_v1) begin
          r_id2   <= r_id1;
          r_prod2 <= w_prod;
        end
      end
      if (w_adv1) begin
        r_v1 <= w_hs;
        if (w_hs) begin
          r_a1  <= w_sel_a;
          r_b1  <= w_sel_b;
          r_id1 <= w_grant_id;
        end
      end
    end
  end

  assign rsp_valid = r_v2;
  assign rsp_id    = r_id2;
  assign rsp_data  = r_prod2;
  assign op_count  = r_op_count;
endmodule

// File: tb/tb_drum_mul_share_arbiter.sv
// Directed bench for drum_mul_share_arbiter: arithmetic, round-robin order, backpressure,
// asynchronous reset mid-flight and op_count wrap.

module tb_drum_mul_share_arbiter;
  localparam int N_REQ = 4;
  localparam int K     = 6;
  localparam int N     = 16;
  localparam int M     = 16;
  localparam int ID_W  = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ*N-1:0] req_a;
  logic [N_REQ*M-1:0] req_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [ID_W-1:0]    rsp_id;
  logic [N+M-1:0]     rsp_data;
  logic [31:0]        op_count;

  int n_checks = 0;
  int n_pass   = 0;

  drum_mul_share_arbiter #(.N_REQ(N_REQ), .K(K), .N(N), .M(M), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Software DRUM: halve the magnitude until it fits in K bits, then set the LSB if anything was dropped.
  function automatic logic [31:0] drum_model(input logic signed [15:0] a, input logic signed [15:0] b);
    longint ma, mb, p;
    int sa, sb;
    logic [31:0] r;
    ma = (a < 0) ? -longint'(a) - 1 : longint'(a);
    mb = (b < 0) ? -longint'(b) - 1 : longint'(b);
    sa = 0;
    sb = 0;
    while (ma >= (longint'(1) << K)) begin ma = ma >> 1; sa++; end
    while (mb >= (longint'(1) << K)) begin mb = mb >> 1; sb++; end
    if (sa > 0) ma = ma | 1;
    if (sb > 0) mb = mb | 1;
    p = (ma * mb) << (sa + sb);
    r = 32'(p);
    if ((a < 0) != (b < 0)) r = ~r;
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic single(input int id, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp, input string tag);
    @(negedge clk);
    req_a[id*N +: N] = a;
    req_b[id*M +: M] = b;
    req_valid        = '0;
    req_valid[id]    = 1'b1;
    rsp_ready        = 1'b1;
    #1 check({tag, " ready"}, req_ready, 64'(1) << id);
    @(negedge clk);
    req_valid = '0;
    check({tag, " s1 only"}, rsp_valid, 0);
    @(negedge clk);
    check({tag, " valid"}, rsp_valid, 1);
    check({tag, " id"}, rsp_id, id);
    check({tag, " data"}, rsp_data, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    req_valid = 4'hF;
    #1;
    check("reset rsp_valid", rsp_valid, 0);
    check("reset rsp_id", rsp_id, 0);
    check("reset rsp_data", rsp_data, 0);
    check("reset op_count", op_count, 0);
    check("reset req_ready", req_ready, 0);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;

    // Arithmetic: exact, approximated, and one's-complement signed cases
    single(2, 16'd3, 16'd5, 32'd15, "exact");
    single(1, 16'd1000, 16'd5, 32'd5040, "approx");
    single(0, 16'hFFFD, 16'd5, 32'hFFFF_FFF5, "neg_pos");
    single(3, 16'hFC18, 16'hFFFB, 32'd4032, "neg_neg");
    single(2, 16'h7FFF, 16'h7FFF, 32'h3E04_0000, "max_max");
    single(1, 16'h8000, 16'h0002, 32'hFFFF_03FF, "min_pos");
    for (int i = 0; i < 4; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      single(i, ra, rb, drum_model(ra, rb), $sformatf("rand%0d", i));
    end
    check("op_count after singles", op_count, 10);

    // Fairness: all requesters valid, grant order 0,1,2,3,0,1,2,3
    do_reset();
    for (int i = 0; i < N_REQ; i++) begin
      req_a[i*N +: N] = 16'(i + 1);
      req_b[i*M +: M] = 16'd10;
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req_valid = 4'hF;
      if (i >= 2) begin
        check($sformatf("rr rsp_valid c%0d", i), rsp_valid, 1);
        check($sformatf("rr rsp_id c%0d", i), rsp_id, (i - 2) % 4);
        check($sformatf("rr rsp_data c%0d", i), rsp_data, (((i - 2) % 4) + 1) * 10);
      end else begin
        check($sformatf("rr empty c%0d", i), rsp_valid, 0);
      end
      #1 check($sformatf("rr grant c%0d", i), req_ready, 64'(1) << (i % 4));
    end
    @(negedge clk);
    req_valid = '0;
    check("rr op_count", op_count, 8);
    check("rr tail id 2", rsp_id, 2);
    check("rr tail data 2", rsp_data, 30);
    @(negedge clk);
    check("rr tail id 3", rsp_id, 3);
    check("rr tail data 3", rsp_data, 40);
    @(negedge clk);
    check("rr drained", rsp_valid, 0);

    // Backpressure: capacity of two, stable outputs, in-order drain
    do_reset();
    for (int i = 0; i < 3; i++) begin
      req_a[i*N +: N] = 16'd7;
      req_b[i*M +: M] = 16'(i + 1);
    end
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 4'b0111;
    #1 check("bp grant 0", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = 4'b0110;
    check("bp s2 empty", rsp_valid, 0);
    #1 check("bp grant 1", req_ready, 4'b0010);
    for (int c = 2; c < 6; c++) begin
      @(negedge clk);
      req_valid = 4'b0100;
      check($sformatf("bp hold valid c%0d", c), rsp_valid, 1);
      check($sformatf("bp hold id c%0d", c), rsp_id, 0);
      check($sformatf("bp hold data c%0d", c), rsp_data, 7);
      check($sformatf("bp op_count c%0d", c), op_count, 2);
      #1 check($sformatf("bp third blocked c%0d", c), req_ready, 0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    check("bp drain id 0", rsp_id, 0);
    #1 check("bp grant 2", req_ready, 4'b0100);
    @(negedge clk);
    req_valid = '0;
    check("bp drain id 1", rsp_id, 1);
    check("bp drain data 1", rsp_data, 14);
    @(negedge clk);
    check("bp drain id 2", rsp_id, 2);
    check("bp drain data 2", rsp_data, 21);
    check("bp op_count", op_count, 3);
    @(negedge clk);
    check("bp no duplicate", rsp_valid, 0);

    // Asynchronous reset with both stages full
    do_reset();
    req_a[0 +: N] = 16'd4;
    req_b[0 +: M] = 16'd6;
    rsp_ready     = 1'b0;
    @(negedge clk);
    req_valid = 4'b1010;
    #1 check("mr grant 1", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = 4'b1000;
    #1 check("mr grant 3", req_ready, 4'b1000);
    @(negedge clk);
    req_valid = '0;
    check("mr full", rsp_valid, 1);
    #2 rst = 1'b1;
    req_valid = 4'hF;
    #1;
    check("mr rsp_valid drop", rsp_valid, 0);
    check("mr op_count", op_count, 0);
    check("mr ready in reset", req_ready, 0);
    @(negedge clk);
    rst       = 1'b0;
    rsp_ready = 1'b1;
    #1 check("mr next grant 0", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    check("mr no stale", rsp_valid, 0);
    @(negedge clk);
    check("mr fresh valid", rsp_valid, 1);
    check("mr fresh id", rsp_id, 0);
    check("mr fresh data", rsp_data, 24);
    @(negedge clk);
    check("mr drained", rsp_valid, 0);
    check("mr op_count one", op_count, 1);

    // op_count wrap
    @(negedge clk);
    force dut.r_op_count = 32'hFFFF_FFFF;
    #1 release dut.r_op_count;
    req_valid = 4'b0001;
    #1 check("wrap grant", req_ready, 4'b0001);
    @(negedge clk);
    check("wrap to zero", op_count, 0);
    @(negedge clk);
    req_valid = '0;
    check("wrap to one", op_count, 1);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
